// File: rtl/pattern_stream_tx_pkg.sv
// Shared types and constants for the "0101" pattern transmitter and its detector side.
package pattern_stream_tx_pkg;

  typedef enum logic [3:0] {
    IDLE, LEAD0, LEAD1, PAIR0, PAIR1, S0, S1, S2, S3, GAP, DONE
  } tx_state_t;

  localparam logic MODE_OVERLAP = 1'b0;
  localparam logic MODE_SPACED  = 1'b1;
  localparam logic IDLE_BIT     = 1'b1;
  localparam logic [3:0] PATTERN = 4'b0101;

  // Line level driven in each state; the pattern MSB goes out first.
  function automatic logic state_bit(tx_state_t s);
    case (s)
      LEAD0, PAIR0, S0: state_bit = PATTERN[3];
      LEAD1, PAIR1, S1: state_bit = PATTERN[2];
      S2:               state_bit = PATTERN[1];
      S3:               state_bit = PATTERN[0];
      default:          state_bit = IDLE_BIT;
    endcase
  endfunction

endpackage

// File: rtl/pattern_stream_tx_gap.sv
// Loadable down-counter timing the idle-'1' run after each spaced-mode occurrence.
module tx_gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pattern_stream_tx.sv
// Serial "0101" stream generator: emits exactly the requested number of overlap-counted
// occurrences, either packed back-to-back or separated by idle-'1' gaps.
module pattern_stream_tx
  import pattern_stream_tx_pkg::*;
#(
  parameter int GAP_BITS = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             mode_i,
  input  logic             en_i,
  output logic             bit_o,
  output logic             bit_vld_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] occ_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       GAP_LOAD = 4'(GAP_BITS - 1);

  tx_state_t        state, state_nxt;
  logic             mode_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] occ_q;
  logic             zero_hold_q;
  logic             accept, occ_step, tmr_load, tmr_en, tmr_zero;

  tx_gap_timer #(.W(4)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (GAP_LOAD),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= MODE_OVERLAP;
      rem_q       <= '0;
      occ_q       <= '0;
      zero_hold_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_q      <= mode_i;
        rem_q       <= count_i;
        occ_q       <= '0;
        zero_hold_q <= (count_i == '0);
      end else begin
        zero_hold_q <= 1'b0;
        if (occ_step) begin
          occ_q <= occ_q + CNT_ONE;
          rem_q <= rem_q - CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    bit_o     = IDLE_BIT;
    bit_vld_o = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    accept    = 1'b0;
    occ_step  = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (req_i) begin
          accept = 1'b1;
          if (count_i == '0)             state_nxt = DONE;
          else if (mode_i == MODE_SPACED) state_nxt = S0;
          else                            state_nxt = LEAD0;
        end
      end
      LEAD0, LEAD1, PAIR0, PAIR1, S0, S1, S2, S3, GAP: begin
        busy_o    = 1'b1;
        bit_vld_o = 1'b1;
        bit_o     = state_bit(state);
        tmr_en    = (state == GAP) && en_i;
        if (en_i) begin
          case (state)
            LEAD0: state_nxt = LEAD1;
            LEAD1: state_nxt = PAIR0;
            PAIR0: state_nxt = PAIR1;
            PAIR1: begin
              occ_step  = 1'b1;
              state_nxt = (rem_q == CNT_ONE) ? DONE : PAIR0;
            end
            S0: state_nxt = S1;
            S1: state_nxt = S2;
            S2: state_nxt = S3;
            S3: begin
              occ_step  = 1'b1;
              tmr_load  = 1'b1;
              state_nxt = GAP;
            end
            GAP: begin
              // rem_q was already decremented when S3 was consumed
              if (tmr_zero) state_nxt = (rem_q == '0) ? DONE : S0;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
      DONE: begin
        // A zero-count frame spends its single busy cycle here before the done pulse.
        if (zero_hold_q) begin
          busy_o = 1'b1;
        end else begin
          done_o    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign occ_cnt_o = occ_q;

endmodule

// File: tb/tb_pattern_stream_tx.sv
// Directed, table-driven bench for pattern_stream_tx with a small overlap-aware "0101" detector model.
module tb_pattern_stream_tx;

  logic       clk = 1'b0;
  logic       rst, req, mode, en;
  logic [7:0] cnt;
  logic       bit_o, bit_vld, busy, done;
  logic [7:0] occ;

  pattern_stream_tx #(.GAP_BITS(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .count_i   (cnt),
    .mode_i    (mode),
    .en_i      (en),
    .bit_o     (bit_o),
    .bit_vld_o (bit_vld),
    .busy_o    (busy),
    .done_o    (done),
    .occ_cnt_o (occ)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          count;
    int          mode;
    int          tog;
    int          done_cy;
    int          nbits;
    logic [15:0] stream;
    int          occ;
  } vec_t;

  vec_t vecs[7];

  int n_pass = 0;
  int n_total = 0;

  int          r_done_cy, r_nbits, r_occ, r_det, r_busy1, r_viol;
  logic [15:0] r_stream;
  logic [3:0]  det_sr;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests one frame and follows it to its done pulse, logging consumed bits.
  task automatic run_frame(input int c, input int m, input int tog, input int hold, input int alt);
    req  = 1'b1;
    cnt  = 8'(c);
    mode = m[0];
    en   = 1'b1;
    tick();
    if (hold == 0) req = 1'b0;
    r_done_cy = -1;
    r_nbits   = 0;
    r_occ     = -1;
    r_det     = 0;
    r_viol    = 0;
    r_busy1   = 0;
    r_stream  = '0;
    det_sr    = 4'hF;
    for (int cy = 1; cy <= 2000; cy++) begin
      en = (tog != 0) ? (cy % 2 == 0) : 1'b1;
      if (cy == 2) cnt = 8'(alt);
      if (cy == 3) mode = ~mode;
      if (cy == 1) r_busy1 = int'(busy);
      if (bit_vld && !busy) r_viol++;
      if (!bit_vld && bit_o !== 1'b1) r_viol++;
      if (done && (busy || bit_vld)) r_viol++;
      if (done) begin
        r_done_cy = cy;
        r_occ     = int'(occ);
        break;
      end
      if (bit_vld && en) begin
        r_stream = {r_stream[14:0], bit_o};
        r_nbits++;
        det_sr = {det_sr[2:0], bit_o};
        if (det_sr == 4'b0101) r_det++;
      end
      tick();
    end
  endtask

  task automatic do_vec(input vec_t v, input string name, input int hold, input int alt);
    run_frame(v.count, v.mode, v.tog, hold, alt);
    check({name, " busy_cycle1"}, r_busy1, 1);
    check({name, " done_cycle"}, r_done_cy, v.done_cy);
    check({name, " nbits"}, r_nbits, v.nbits);
    check({name, " stream"}, int'(r_stream), int'(v.stream));
    check({name, " occ_at_done"}, r_occ, v.occ);
    check({name, " detector"}, r_det, v.occ);
    check({name, " line_rules"}, r_viol, 0);
    tick();
    check({name, " occ_hold"}, int'(occ), v.occ);
  endtask

  initial begin
    vecs[0] = '{count: 3, mode: 0, tog: 0, done_cy: 9,  nbits: 8,  stream: 16'h0055, occ: 3};
    vecs[1] = '{count: 2, mode: 1, tog: 0, done_cy: 13, nbits: 12, stream: 16'h05D7, occ: 2};
    vecs[2] = '{count: 0, mode: 0, tog: 0, done_cy: 2,  nbits: 0,  stream: 16'h0000, occ: 0};
    vecs[3] = '{count: 1, mode: 0, tog: 1, done_cy: 9,  nbits: 4,  stream: 16'h0005, occ: 1};
    vecs[4] = '{count: 1, mode: 1, tog: 0, done_cy: 7,  nbits: 6,  stream: 16'h0017, occ: 1};
    vecs[5] = '{count: 5, mode: 0, tog: 0, done_cy: 13, nbits: 12, stream: 16'h0555, occ: 5};
    vecs[6] = '{count: 1, mode: 1, tog: 1, done_cy: 13, nbits: 6,  stream: 16'h0017, occ: 1};

    rst = 1'b1; req = 1'b0; mode = 1'b0; en = 1'b0; cnt = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    check("reset bit_o", int'(bit_o), 1);
    check("reset bit_vld", int'(bit_vld), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset occ", int'(occ), 0);

    en = 1'b1;
    tick(); tick();
    check("idle en busy", int'(busy), 0);
    check("idle en vld", int'(bit_vld), 0);

    for (int i = 0; i < 7; i++) begin
      do_vec(vecs[i], $sformatf("vec%0d", i), 0, vecs[i].count);
    end

    // Reset during PAIR0 of a count=5 frame, after one occurrence.
    req = 1'b1; cnt = 8'd5; mode = 1'b0; en = 1'b1;
    tick();
    req = 1'b0;
    tick(); tick(); tick(); tick();
    check("midrst pre occ", int'(occ), 1);
    check("midrst pre bit", int'(bit_o), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst bit_o", int'(bit_o), 1);
    check("midrst vld", int'(bit_vld), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst occ", int'(occ), 0);
    check("midrst done", int'(done), 0);
    tick();
    check("midrst no_done", int'(done), 0);
    do_vec('{count: 2, mode: 0, tog: 0, done_cy: 7, nbits: 6, stream: 16'h0015, occ: 2},
           "after_rst", 0, 2);

    // req held high while count_i moves from 4 to 7 mid-frame.
    run_frame(4, 0, 0, 1, 7);
    check("gate done_cycle", r_done_cy, 11);
    check("gate stream", int'(r_stream), 16'h0155);
    check("gate occ", r_occ, 4);
    check("gate detector", r_det, 4);
    tick();
    check("gate idle gap busy", int'(busy), 0);
    do_vec('{count: 7, mode: 0, tog: 0, done_cy: 17, nbits: 16, stream: 16'h5555, occ: 7},
           "gate2", 0, 7);

    do_vec('{count: 255, mode: 0, tog: 0, done_cy: 513, nbits: 512, stream: 16'h5555, occ: 255},
           "max", 0, 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
